decode_stage: RTL
=================

# decode_stage

Pipelined RV32I instruction decode stage for the 32-bit RISC-V core; the parametrised successor to the single-cycle field splitter. Sits between instruction fetch and register-file read. Accepts one 32-bit instruction per valid/ready handshake and registers the decoded fields with one cycle of latency. Covers all base formats (R/I/S/B/U/J), emits byte-offset immediates sign-extended to `XLEN`, flags illegal encodings, and supports a pipeline flush.

## Interface
- `XLEN`, 32: immediate output width. Legal values are 32 and 64.
- `CHECK_FUNCT`, 1: when 1, illegal func3/func7 combinations raise `illegal`. When 0, only the opcode is checked.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `instruction` input 32: raw instruction word.
- `flush` input 1: discard the held decode and any input presented this cycle.
- `out_valid` output 1: decoded fields are valid.
- `out_ready` input 1: downstream accepts the fields.
- `opcode` output 7, `func3` output 3, `func7` output 7.
- `rs1`, `rs2`, `rd` output 5 each.
- `imm` output XLEN: sign-extended byte offset. It is never pre-shifted.
- `fmt` output 3: instruction format code, from the package.
- `size` output 2: memory access size. 0 = byte, 1 = half, 2 = word.
- `mem_unsigned` output 1: load is LBU or LHU.
- `rs1_used`, `rs2_used`, `rd_we` output 1 each: operand-use flags.
- `illegal` output 1: the held instruction is undecodable.

## Operation
- Supported opcodes: R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111).
- Field extraction:
  - rd = [11:7]
  - func3 = [14:12]
  - rs1 = [19:15]
  - rs2 = [24:20]
  - func7 = [31:25]
- Unused fields are driven to 0, never X. rd is 0 for S and B. rs1 is 0 for U and J. rs2 is 0 for I, U and J. func7 is 0 except for R and for I-shift instructions.
- Immediates are sign-extended from instr[31]:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - R: imm = 0.
- `size` and `mem_unsigned` derive from func3 for LOAD and STORE; otherwise `size` = 2 and `mem_unsigned` = 0.
- `rd_we` is 1 for R, I, LOAD, JAL, JALR, LUI and AUIPC. It is forced to 0 when rd = 0 or when `illegal` = 1.
- `illegal` conditions:
  - Unknown opcode.
  - instr[1:0] ≠ 2'b11.
  - With `CHECK_FUNCT` = 1:
    - R-type func7 not in {0000000, 0100000}, or func7 = 0100000 with func3 ∉ {000, 101}.
    - LOAD func3 ∈ {011, 110, 111}.
    - STORE func3 > 010.
    - BRANCH func3 ∈ {010, 011}.
    - JALR func3 ≠ 000.
- An illegal instruction still propagates with `out_valid`. Its fields are as extracted, and all use flags are 0.

## Timing
- Reset (async assert, sync release): `out_valid` = 0 and every output field = 0. `in_ready` is 1 after reset.
- `in_ready` = !flush && (!out_valid || out_ready). This is combinational and permits back-to-back throughput of 1 instruction/cycle.
- Accept when in_valid && in_ready. Fields register on that edge, and `out_valid` = 1 the following cycle (latency 1).
- When `out_valid` && !`out_ready`, all outputs hold stable and `in_ready` = 0.
- `flush` has priority. On the next edge `out_valid` = 0, the input presented that cycle is not accepted, and fields keep their values.
- Reset asserted mid-transfer returns to the reset state immediately. No pending instruction survives.
- Two-state control only: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY→FULL on accept.
  - FULL→FULL on out_ready && accept.
  - FULL→EMPTY on out_ready && !accept, or on flush.

## Structure
- Package `riscv_pkg` holds:
  - the opcode constants
  - the `fmt` encoding: R=0, I=1, S=2, B=3, U=4, J=5
  - the `size` codes
  - the func3 constants for loads, stores and branches
- Sub-module `imm_gen`: combinational, parametrised by `XLEN`, taking instruction and fmt and producing imm. It is reused later by the execute stage.
- The top level contains the field and flag decode plus the output register and handshake.

## Test plan
- 0xFFF00093 (addi x1,x0,-1) → rd=1, rs1=0, rs2=0, fmt=I, imm=0xFFFFFFFF, rd_we=1, rs2_used=0, out_valid one cycle after accept.
- 0xFE208CE3 (beq x1,x2,-8) → rs1=1, rs2=2, rd=0, fmt=B, imm=0xFFFFFFF8, rd_we=0. With XLEN=64, imm=0xFFFFFFFFFFFFFFF8.
- 0x002081A3 (sb x2,3(x1)) → imm=3, size=0, rd=0, rd_we=0. 0x001000EF (jal x1,+2048) → imm=0x800, rs1=0, rd=1. 0x123452B7 (lui x5,0x12345) → imm=0x12345000.
- Back-to-back stream of 4 instructions with out_ready held low for 2 cycles mid-stream → in_ready=0 and outputs stable while stalled, no instruction lost or duplicated, order preserved.
- 0x00000000 and 0x4000F0B3 (bad R funct) → illegal=1, rd_we=0. With CHECK_FUNCT=0, 0x4000F0B3 has illegal=0.
- flush asserted while out_valid=1 and in_valid=1 → out_valid=0 next cycle and that input is not accepted. rst_n pulsed low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, format codes, access sizes and func3 values.
// Also holds the registered decode bundle carried from decode to register-file read.
package riscv_pkg;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3SrlSra = 3'b101;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] fmt;
    logic [1:0] size;
    logic       mem_unsigned;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_we;
    logic       illegal;
  } dec_t;

  function automatic logic is_shift_imm(input logic [2:0] f3);
    return (f3 == F3Sll) || (f3 == F3SrlSra);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the byte-offset immediate for a format
// and sign-extends it from instruction[31] to XLEN (32 or 64).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode_bits;

  assign unused_opcode_bits = ^instruction[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      FmtI: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      FmtS: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FmtB: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
      FmtU: imm32 = {instruction[31:12], 12'b0};
      FmtJ: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  if (XLEN > 32) begin : g_ext
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_noext
    assign imm = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: splits fields, flags illegal encodings and registers the result
// behind a one-entry valid/ready skid-free output register (latency 1, full throughput).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          CHECK_FUNCT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [1:0]      size,
  output logic            mem_unsigned,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            rd_we,
  output logic            illegal
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  dec_t            dec_d, dec_q;
  logic [XLEN-1:0] imm_d, imm_q;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  fmt_e       fmt_c;
  logic       known, rs1_c, rs2_c, we_c, is_load, is_store, is_shift, bad_funct, illegal_c;
  logic       accept;

  assign op = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];

  // Opcode classification; unknown opcodes fall back to R so fields are still extracted.
  always_comb begin
    fmt_c     = FmtR;
    known     = 1'b0;
    rs1_c     = 1'b0;
    rs2_c     = 1'b0;
    we_c      = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_shift  = 1'b0;
    bad_funct = 1'b0;
    case (op)
      OpReg: begin
        fmt_c     = FmtR;
        known     = 1'b1;
        rs1_c     = 1'b1;
        rs2_c     = 1'b1;
        we_c      = 1'b1;
        bad_funct = !((f7 == F7Base) ||
                      ((f7 == F7Alt) && ((f3 == F3AddSub) || (f3 == F3SrlSra))));
      end
      OpImm: begin
        fmt_c    = FmtI;
        known    = 1'b1;
        rs1_c    = 1'b1;
        we_c     = 1'b1;
        is_shift = is_shift_imm(f3);
      end
      OpLoad: begin
        fmt_c     = FmtI;
        known     = 1'b1;
        rs1_c     = 1'b1;
        we_c      = 1'b1;
        is_load   = 1'b1;
        bad_funct = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OpStore: begin
        fmt_c     = FmtS;
        known     = 1'b1;
        rs1_c     = 1'b1;
        rs2_c     = 1'b1;
        is_store  = 1'b1;
        bad_funct = (f3 > F3Sw);
      end
      OpBranch: begin
        fmt_c     = FmtB;
        known     = 1'b1;
        rs1_c     = 1'b1;
        rs2_c     = 1'b1;
        bad_funct = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpJal: begin
        fmt_c = FmtJ;
        known = 1'b1;
        we_c  = 1'b1;
      end
      OpJalr: begin
        fmt_c     = FmtI;
        known     = 1'b1;
        rs1_c     = 1'b1;
        we_c      = 1'b1;
        bad_funct = (f3 != 3'b000);
      end
      OpLui, OpAuipc: begin
        fmt_c = FmtU;
        known = 1'b1;
        we_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_c = !known || (instruction[1:0] != 2'b11) || (CHECK_FUNCT && bad_funct);

  always_comb begin
    dec_d              = '0;
    dec_d.opcode       = op;
    dec_d.fmt          = fmt_c;
    dec_d.illegal      = illegal_c;
    dec_d.func3        = ((fmt_c == FmtU) || (fmt_c == FmtJ)) ? 3'b0 : f3;
    dec_d.rs1          = ((fmt_c == FmtU) || (fmt_c == FmtJ)) ? 5'b0 : instruction[19:15];
    dec_d.rs2          = ((fmt_c == FmtR) || (fmt_c == FmtS) || (fmt_c == FmtB)) ?
                         instruction[24:20] : 5'b0;
    dec_d.rd           = ((fmt_c == FmtS) || (fmt_c == FmtB)) ? 5'b0 : instruction[11:7];
    dec_d.func7        = ((fmt_c == FmtR) || is_shift) ? f7 : 7'b0;
    dec_d.size         = (is_load || is_store) ? f3[1:0] : SizeWord;
    dec_d.mem_unsigned = is_load && ((f3 == F3Lbu) || (f3 == F3Lhu));
    dec_d.rs1_used     = rs1_c && !illegal_c;
    dec_d.rs2_used     = rs2_c && !illegal_c;
    dec_d.rd_we        = we_c && !illegal_c && (instruction[11:7] != 5'd0);
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instruction(instruction),
    .fmt        (fmt_c),
    .imm        (imm_d)
  );

  assign out_valid = (state_q == StFull);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  // Fields are only written on accept, so a flush leaves the last decode visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      dec_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dec_q <= dec_d;
        imm_q <= imm_d;
      end
    end
  end

  assign opcode       = dec_q.opcode;
  assign func3        = dec_q.func3;
  assign func7        = dec_q.func7;
  assign rs1          = dec_q.rs1;
  assign rs2          = dec_q.rs2;
  assign rd           = dec_q.rd;
  assign imm          = imm_q;
  assign fmt          = dec_q.fmt;
  assign size         = dec_q.size;
  assign mem_unsigned = dec_q.mem_unsigned;
  assign rs1_used     = dec_q.rs1_used;
  assign rs2_used     = dec_q.rs2_used;
  assign rd_we        = dec_q.rd_we;
  assign illegal      = dec_q.illegal;

endmodule
